// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, the VRAM window
// in the CPU map and the grant encoding used by the port mux and read pipe.
package vram_pkg;

  localparam int          VRAM_ADDR_W = 13;
  localparam int          VRAM_DATA_W = 16;
  localparam logic [15:0] VRAM_BASE   = 16'h4000;
  localparam logic [15:0] VRAM_SIZE   = 16'h2000;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// Two-stage read pipe: stage 1 tags the issued access with its owner, stage 2
// captures ram_rdata (valid one cycle after issue) for the video or CPU side.
module vram_rd_pipe
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  gnt_e              issue_i,
  input  logic              issue_we_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              s1_vid_o,
  output logic              s1_cpu_o,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o
);

  logic s1_we_q;

  // Owner shift register; a CPU write acks without disturbing cpu_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vid_o    <= 1'b0;
      s1_cpu_o    <= 1'b0;
      s1_we_q     <= 1'b0;
      vid_valid_o <= 1'b0;
      vid_rdata_o <= {DATA_W{1'b0}};
      cpu_ack_o   <= 1'b0;
      cpu_rdata_o <= {DATA_W{1'b0}};
    end else begin
      s1_vid_o    <= (issue_i == GNT_VID);
      s1_cpu_o    <= (issue_i == GNT_CPU);
      s1_we_q     <= issue_we_i;
      vid_valid_o <= s1_vid_o;
      cpu_ack_o   <= s1_cpu_o;
      if (s1_vid_o) begin
        vid_rdata_o <= ram_rdata_i;
      end
      if (s1_cpu_o && !s1_we_q) begin
        cpu_rdata_o <= ram_rdata_i;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between video scanout (priority) and the CPU, with
// a starvation guard. Optional VRAM_ARB_STATS_EN adds the cpu_stall_cycles counter.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int MAX_VID_RUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cycles
`endif
);

  localparam int               RUN_W   = $clog2(MAX_VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

  gnt_e              gnt;
  logic              cpu_eligible;
  logic              cpu_inflight;
  logic              s1_vid;
  logic              s1_cpu;
  logic [RUN_W-1:0]  run_q;
  logic [RUN_W-1:0]  run_d;
  logic [ADDR_W-1:0] addr_q;

  // The CPU slot stays closed from the cycle after its grant through its ack.
  assign cpu_inflight = s1_cpu | cpu_ack;
  assign cpu_eligible = cpu_req & ~cpu_inflight;
  assign busy         = vid_req | s1_vid | vid_valid;
  assign vid_gnt      = (gnt == GNT_VID);

  // Grant decision and VRAM port mux; nothing is issued while reset is held.
  always_comb begin
    gnt       = GNT_NONE;
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (cpu_eligible && (!vid_req || run_q == RUN_MAX)) begin
      gnt = GNT_CPU;
    end else if (vid_req) begin
      gnt = GNT_VID;
    end else begin
      gnt = GNT_NONE;
    end
    case (gnt)
      GNT_CPU: begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
      end
      GNT_VID: begin
        ram_addr = vid_addr;
      end
      default: begin
        ram_addr = addr_q;
      end
    endcase
  end

  // Length of the current video run seen by a waiting CPU request.
  always_comb begin
    run_d = run_q;
    if (gnt == GNT_CPU || !cpu_eligible) begin
      run_d = {RUN_W{1'b0}};
    end else if (gnt == GNT_VID && run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end else begin
      run_d = run_q;
    end
  end

  // Run counter and the held VRAM address for idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= {RUN_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      run_q  <= run_d;
      addr_q <= ram_addr;
    end
  end

  vram_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue_i    (gnt),
    .issue_we_i (ram_we),
    .ram_rdata_i(ram_rdata),
    .s1_vid_o   (s1_vid),
    .s1_cpu_o   (s1_cpu),
    .vid_valid_o(vid_valid),
    .vid_rdata_o(vid_rdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_rdata_o(cpu_rdata)
  );

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the CPU was eligible but not granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else if (cpu_eligible && gnt != GNT_CPU && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'h0001;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign cpu_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: requester drivers, a VRAM model, a cycle-level
// reference of the arbitration rules feeding a scoreboard, and directed checks.
module tb_vram_arbiter;
  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int MAXR = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_gnt, vid_valid, busy, ram_we;
  logic [DW-1:0] vid_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   cpu_stall_cycles;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_valid(vid_valid), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .cpu_stall_cycles(cpu_stall_cycles)
`endif
  );

  // VRAM: single port, read-first, one cycle read latency.
  logic [DW-1:0] vram [0:8191];
  always @(posedge clk) begin
    if (ram_we) vram[ram_addr] <= ram_wdata;
    ram_rdata <= vram[ram_addr];
  end

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester controls written by the main sequence, consumed by the driver.
  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  op_t cpu_ops[$];
  int  op_idx = 0, vid_done = 0, vid_quota = 0, vid_mark = 0;
  bit  vid_rand = 1'b0, cpu_rand = 1'b0;

  initial begin : driver
    bit g, a;
    op_t op;
    forever begin
      @(negedge clk);
      g = vid_gnt;
      a = cpu_ack;
      @(posedge clk);
      #1;
      if (vid_req && g) begin
        vid_done++;
        vid_req = 1'b0;
      end
      if (!vid_req && vid_done < vid_quota && (!vid_rand || $urandom_range(0, 2) != 0)) begin
        vid_addr = vid_rand ? AW'($urandom_range(0, 31)) : AW'(vid_done - vid_mark);
        vid_req  = 1'b1;
      end
      if (cpu_req && a) cpu_req = 1'b0;
      if (!cpu_req && op_idx < cpu_ops.size() && (!cpu_rand || $urandom_range(0, 1) == 0)) begin
        op = cpu_ops[op_idx];
        op_idx++;
        cpu_we    = op.we;
        cpu_addr  = op.a;
        cpu_wdata = op.d;
        cpu_req   = 1'b1;
      end
    end
  end

  // Reference: arbitration rules as plain counters plus a mirror of VRAM contents.
  typedef struct { int due; logic [DW-1:0] data; bit rd; } exp_t;
  exp_t          vq[$], cq[$];
  logic [DW-1:0] ref_mem [0:8191];
  int            run_m = 0, cpu_free = 0, vid_last = -100, stall_m = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    bit elig, gc, gv;
    logic [AW-1:0] ea;
    if (chk_on) begin
      elig = cpu_req && (cyc >= cpu_free);
      gc = 1'b0;
      gv = 1'b0;
      if (!reset) begin
        if (elig && (!vid_req || run_m >= MAXR)) gc = 1'b1;
        else if (vid_req) gv = 1'b1;
      end
      ea = gc ? cpu_addr : (gv ? vid_addr : last_addr);
      chk("vid_gnt", vid_gnt, gv);
      chk("ram_we", ram_we, gc && cpu_we);
      chk("ram_addr", ram_addr, ea);
      if (gc && cpu_we) chk("ram_wdata", ram_wdata, cpu_wdata);
      chk("busy", busy, vid_req || (cyc <= vid_last + 2));
`ifdef VRAM_ARB_STATS_EN
      chk("stall_cnt", cpu_stall_cycles, stall_m);
`endif
      if (reset) begin
        run_m = 0; cpu_free = 0; vid_last = -100; last_addr = '0; stall_m = 0;
      end else begin
        if (elig && !gc && stall_m < 65535) stall_m++;
        last_addr = ea;
        if (gc) begin
          cpu_free = cyc + 3;
          run_m = 0;
          if (cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            cq.push_back('{due: cyc + 2, data: '0, rd: 1'b0});
          end else begin
            cq.push_back('{due: cyc + 2, data: ref_mem[cpu_addr], rd: 1'b1});
          end
        end else if (gv) begin
          vid_last = cyc;
          vq.push_back('{due: cyc + 2, data: ref_mem[vid_addr], rd: 1'b1});
          run_m = elig ? ((run_m < MAXR) ? run_m + 1 : MAXR) : 0;
        end else begin
          run_m = 0;
        end
      end
    end
  end

  // Monitor: pops expectations when they fall due; reset discards in-flight ones.
  logic [DW-1:0] hold_m = '0;
  always @(negedge clk) begin
    bit ev, ec;
    if (chk_on) begin
      ev = (vq.size() > 0) && (vq[0].due == cyc);
      chk("vid_valid", vid_valid, ev);
      if (ev) begin
        chk("vid_rdata", vid_rdata, vq[0].data);
        void'(vq.pop_front());
      end
      ec = (cq.size() > 0) && (cq[0].due == cyc);
      chk("cpu_ack", cpu_ack, ec);
      if (ec) begin
        if (cq[0].rd) hold_m = cq[0].data;
        chk("cpu_rdata", cpu_rdata, hold_m);
        void'(cq.pop_front());
      end
      if (reset) begin
        vq.delete();
        cq.delete();
        hold_m = '0;
      end
    end
  end

  task automatic push_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t op;
    op.we = we; op.a = a; op.d = d;
    cpu_ops.push_back(op);
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while ((op_idx < cpu_ops.size() || cpu_req || vid_req || vid_done < vid_quota ||
            vq.size() > 0 || cq.size() > 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < maxc, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  int n, v, fv, lv, nv, nb, iv, ic, stall_base;

  initial begin : main
    for (int i = 0; i < 8192; i++) begin
      vram[i]    = DW'(i) ^ 16'hA5A5;
      ref_mem[i] = DW'(i) ^ 16'hA5A5;
    end
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_vid_valid", vid_valid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk("rst_vid_rdata", vid_rdata, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;

    // CPU write then read back.
    @(negedge clk);
    push_op(1'b1, 13'h0010, 16'hBEEF);
    push_op(1'b0, 13'h0010, 16'h0000);
    drain("drain_cpu", 60);
    chk("cpu_readback", cpu_rdata, 16'hBEEF);

    // Video stream of 16 over addresses 0..15.
    vid_mark = vid_quota;
    vid_quota = vid_quota + 16;
    fv = -1; lv = -1; nv = 0; nb = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (vid_valid) begin
        if (fv < 0) fv = i;
        lv = i;
        nv++;
      end
      if (busy) nb++;
    end
    chk("stream_first_valid", fv, 2);
    chk("stream_last_valid", lv, 17);
    chk("stream_valid_count", nv, 16);
    chk("stream_busy_cycles", nb, 18);
    drain("drain_stream", 40);

    // Contention: constant video, one CPU read.
    stall_base = stall_m;
    vid_quota = vid_quota + 24;
    push_op(1'b0, 13'h0100, 16'h0000);
    n = 0; v = 0;
    do begin
      @(negedge clk);
      n++;
      if (!cpu_ack && vid_gnt) v++;
    end while (!cpu_ack && n < 60);
    chk("contention_ack_cycle", n, 11);
    chk("contention_vid_before_ack", v, 9);
    chk("contention_rdata", cpu_rdata, 16'h0100 ^ 16'hA5A5);
`ifdef VRAM_ARB_STATS_EN
    chk("stall_at_ack", cpu_stall_cycles, 16'(stall_base + 8));
`endif
    drain("drain_contention", 80);

    // Simultaneous single requests.
    vid_quota = vid_quota + 1;
    push_op(1'b0, 13'h0020, 16'h0000);
    iv = -1; ic = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vid_valid && iv < 0) iv = i;
      if (cpu_ack && ic < 0) ic = i;
    end
    chk("simul_vid_valid_at", iv, 2);
    chk("simul_cpu_ack_at", ic, 3);
    drain("drain_simul", 40);

    // Reset the cycle after a CPU read grant.
    push_op(1'b0, 13'h0010, 16'h0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_req && n < 20);
    chk("rst_test_req_seen", cpu_req, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_ack", cpu_ack, 1'b0);
    chk("midrst_cpu_rdata", cpu_rdata, 16'h0000);
    chk("midrst_vid_valid", vid_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    drain("drain_reset", 40);
    chk("post_reset_read", cpu_rdata, 16'hBEEF);

    // Randomized mix with overlapping CPU writes and video reads.
    vid_rand = 1'b1;
    cpu_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
    end
    vid_quota = vid_quota + 150;
    drain("drain_random", 4000);
    vid_rand = 1'b0;
    cpu_rand = 1'b0;

`ifdef VRAM_ARB_STATS_EN
    // Prolonged stall to saturate the counter.
    vid_quota = vid_quota + 100000;
    for (int i = 0; i < 9000; i++) push_op(1'b0, AW'(i), 16'h0000);
    n = 0;
    while (stall_m < 65535 && n < 95000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk("stall_saturated", cpu_stall_cycles, 16'hFFFF);
    vid_quota = vid_done;
    op_idx = cpu_ops.size();
    drain("drain_stats", 100);
`endif

    chk("vq_empty", vq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1_500_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
